// File: rtl/covert_pkg.sv
// Shared definitions for the environment-mediated covert channel.
// Used by the transmitter (covert_ook_tx) and by the receiver-side decoder.
//   tx_state_t        transmitter frame FSM states
//   DEFAULT_PREAMBLE  frame preamble pattern, sent MSB first
//   BYTE_W            payload width in bits
package covert_pkg;

  localparam int         BYTE_W           = 8;
  localparam logic [7:0] DEFAULT_PREAMBLE = 8'hAB;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    GUARD
  } tx_state_t;

endpackage

// File: rtl/covert_bit_timer.sv
// Loadable down-counter used for both bit windows and the guard interval.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high (count cleared to 0)
//   load      in   load load_val on the next edge (takes priority over counting)
//   load_val  in   TW-bit reload value
//   done      out  count == 0
//   half      out  count == BIT_CYCLES/2 (last cycle of the first Manchester half)
// The counter parks at 0 when not reloaded.
module covert_bit_timer #(
  parameter int TW         = 2,
  parameter int BIT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done,
  output logic          half
);

  localparam logic [TW-1:0] HALF_VAL = TW'(BIT_CYCLES / 2);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);
  assign half = (count == HALF_VAL);

endmodule

// File: rtl/covert_ook_tx.sv
// Covert-channel transmitter: frames each accepted byte as PREAMBLE + 8 data bits
// (both MSB first) and keys every bit onto stress_en, which gates the on-chip load.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high; aborts any frame in progress
//   tx_data       in   8-bit byte to send
//   tx_valid      in   tx_data is valid
//   tx_ready      out  high only in IDLE; byte accepted when tx_valid & tx_ready
//   stress_en     out  registered enable for the stress load
//   bit_strobe    out  one-cycle pulse in the first cycle of every bit window
//   frame_active  out  high during PREAMBLE and DATA
//   frames_sent   out  32-bit count of completed frames (wraps)
//   state         out  current FSM state (tx_state_t encoding), for observation
// Handshake: a transfer happens on any rising edge where tx_valid & tx_ready are both
// high; tx_ready is registered and only asserted while the FSM idles, so tx_data and
// tx_valid are ignored at all other times.
module covert_ook_tx #(
  parameter int               BIT_CYCLES   = 100_000,
  parameter int               GUARD_CYCLES = 50_000,
  parameter int               PRE_W        = 8,
  parameter logic [PRE_W-1:0] PREAMBLE     = covert_pkg::DEFAULT_PREAMBLE,
  parameter bit               MANCHESTER   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [covert_pkg::BYTE_W-1:0] tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         stress_en,
  output logic                         bit_strobe,
  output logic                         frame_active,
  output logic [31:0]                  frames_sent,
  output logic [1:0]                   state
);

  localparam int TMAX = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int FW   = PRE_W + covert_pkg::BYTE_W;
  localparam int IW   = $clog2(FW);

  localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(FW - 1);
  localparam logic [IW-1:0] PRE_LAST   = IW'(PRE_W - 1);

  if (BIT_CYCLES < 2) begin : g_chk_bit_cycles
    $error("covert_ook_tx: BIT_CYCLES must be >= 2");
  end
  if (GUARD_CYCLES < 1) begin : g_chk_guard_cycles
    $error("covert_ook_tx: GUARD_CYCLES must be >= 1");
  end
  if (MANCHESTER && (BIT_CYCLES % 2 != 0)) begin : g_chk_manchester
    $error("covert_ook_tx: BIT_CYCLES must be even when MANCHESTER=1");
  end

  covert_pkg::tx_state_t cur_state;
  logic [FW-1:0]         shreg;     // MSB is the bit currently on air
  logic [IW-1:0]         bit_idx;
  logic                  t_done;
  logic                  t_half;
  logic                  t_load;
  logic [TW-1:0]         t_val;
  logic                  accept;

  assign accept = tx_valid & tx_ready;
  assign state  = cur_state;

  // Reload on accept and at the end of every bit; the last bit reloads the guard length.
  always_comb begin
    t_load = 1'b0;
    t_val  = BIT_LOAD;
    unique case (cur_state)
      covert_pkg::IDLE:     t_load = accept;
      covert_pkg::PREAMBLE,
      covert_pkg::DATA: begin
        if (t_done) begin
          t_load = 1'b1;
          t_val  = (bit_idx == LAST_IDX) ? GUARD_LOAD : BIT_LOAD;
        end
      end
      covert_pkg::GUARD:    t_load = 1'b0;
    endcase
  end

  covert_bit_timer #(
    .TW         (TW),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done),
    .half     (t_half)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= covert_pkg::IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      stress_en    <= 1'b0;
      bit_strobe   <= 1'b0;
      frame_active <= 1'b0;
      tx_ready     <= 1'b0;
      frames_sent  <= '0;
    end else begin
      bit_strobe <= 1'b0;
      unique case (cur_state)
        covert_pkg::IDLE: begin
          if (accept) begin
            cur_state    <= covert_pkg::PREAMBLE;
            shreg        <= {PREAMBLE, tx_data};
            bit_idx      <= '0;
            stress_en    <= PREAMBLE[PRE_W-1];
            bit_strobe   <= 1'b1;
            frame_active <= 1'b1;
            tx_ready     <= 1'b0;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        covert_pkg::PREAMBLE,
        covert_pkg::DATA: begin
          if (t_done) begin
            if (bit_idx == LAST_IDX) begin
              cur_state    <= covert_pkg::GUARD;
              stress_en    <= 1'b0;
              frame_active <= 1'b0;
            end else begin
              shreg      <= {shreg[FW-2:0], 1'b0};
              bit_idx    <= bit_idx + 1'b1;
              stress_en  <= shreg[FW-2];
              bit_strobe <= 1'b1;
              if (bit_idx == PRE_LAST) cur_state <= covert_pkg::DATA;
            end
          end else if (MANCHESTER && t_half) begin
            // Last cycle of the first half: second half carries the inverted bit.
            stress_en <= ~shreg[FW-1];
          end
        end
        covert_pkg::GUARD: begin
          if (t_done) begin
            cur_state   <= covert_pkg::IDLE;
            frames_sent <= frames_sent + 32'd1;
            tx_ready    <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_covert_ook_tx.sv
// Self-checking bench for covert_ook_tx (BIT_CYCLES=4, GUARD_CYCLES=3, PREAMBLE=8'hAB).
// Two instances: dut (on-off keying) and dut_m (Manchester).
module tb_covert_ook_tx;

  localparam int FRAME_LEN = 16 * 4 + 3 + 1;  // bit windows + guard + first idle cycle

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data,  tx_data_m;
  logic        tx_valid, tx_valid_m;
  logic        tx_ready, tx_ready_m;
  logic        stress_en, stress_en_m;
  logic        bit_strobe, bit_strobe_m;
  logic        frame_active, frame_active_m;
  logic [31:0] frames_sent, frames_sent_m;
  logic [1:0]  state, state_m;

  // {tx_ready, frame_active, stress_en, bit_strobe} expected per cycle
  logic [3:0] exp_q[$];
  int         vectors;
  int         errors;
  logic [31:0] exp_frames;

  covert_ook_tx #(
    .BIT_CYCLES(4), .GUARD_CYCLES(3), .PRE_W(8), .PREAMBLE(8'hAB), .MANCHESTER(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .stress_en(stress_en), .bit_strobe(bit_strobe), .frame_active(frame_active),
    .frames_sent(frames_sent), .state(state)
  );

  covert_ook_tx #(
    .BIT_CYCLES(4), .GUARD_CYCLES(3), .PRE_W(8), .PREAMBLE(8'hAB), .MANCHESTER(1'b1)
  ) dut_m (
    .clk(clk), .rst(rst), .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready_m),
    .stress_en(stress_en_m), .bit_strobe(bit_strobe_m), .frame_active(frame_active_m),
    .frames_sent(frames_sent_m), .state(state_m)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void push_frame(input logic [7:0] b, input bit manch);
    logic [15:0] bits;
    logic        s;
    bits = {8'hAB, b};
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        s = bits[15 - k];
        if (manch && c >= 2) s = ~s;
        exp_q.push_back({1'b0, 1'b1, s, (c == 0)});
      end
    end
    repeat (3) exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1000);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({tx_ready, frame_active, stress_en, bit_strobe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000",
               {tx_ready, frame_active, stress_en, bit_strobe});
    end
    vectors++;
    if (frames_sent !== 32'd0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got frames=%0d state=%0d required 0/0", frames_sent, state);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1 || tx_ready_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b required 1/1", tx_ready, tx_ready_m);
    end
    exp_frames = 32'd0;
  endtask

  task automatic test_idle_quiet();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      pulses += int'(bit_strobe);
      vectors++;
      if (stress_en !== 1'b0 || bit_strobe !== 1'b0 || frame_active !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d: got se=%b bs=%b fa=%b required 0", i,
                 stress_en, bit_strobe, frame_active);
      end
    end
    vectors++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL idle_strobes: got %0d required 0", pulses);
    end
  endtask

  task automatic test_ook_frame();
    logic [3:0] exp, obs;
    int strobes;
    strobes = 0;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    push_frame(8'h5A, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      exp = exp_q.pop_front();
      obs = {tx_ready, frame_active, stress_en, bit_strobe};
      strobes += int'(bit_strobe);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ook_frame cyc %0d: got %b required %b", i, obs, exp);
      end
    end
    exp_frames = exp_frames + 32'd1;
    vectors++;
    if (strobes != 16) begin
      errors++;
      $display("FAIL ook_strobes: got %0d required 16", strobes);
    end
    vectors++;
    if (frames_sent !== exp_frames) begin
      errors++;
      $display("FAIL ook_frames_sent: got %0d required %0d", frames_sent, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp, obs;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    push_frame(8'h00, 1'b0);
    push_frame(8'hFF, 1'b0);
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      obs = {tx_ready, frame_active, stress_en, bit_strobe};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_frame cyc %0d: got %b required %b", i, obs, exp);
      end
      // Change tx_data during each frame; only the latched byte may go on air.
      if (i == 0) tx_data = 8'hFF;
      if (i == FRAME_LEN) begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
      end
      if (i == FRAME_LEN + 20) tx_data = 8'h3C;
    end
    exp_frames = exp_frames + 32'd2;
    vectors++;
    if (frames_sent !== exp_frames) begin
      errors++;
      $display("FAIL b2b_frames_sent: got %0d required %0d", frames_sent, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp, obs;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    push_frame(8'hC3, 1'b0);
    // Entry 44 is the first cycle of bit 11 (data bit 3).
    for (int i = 0; i <= 44; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      exp = exp_q.pop_front();
      obs = {tx_ready, frame_active, stress_en, bit_strobe};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_prefix cyc %0d: got %b required %b", i, obs, exp);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 32'd0;
    vectors++;
    if (stress_en !== 1'b0 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got se=%b fa=%b required 0/0", stress_en, frame_active);
    end
    vectors++;
    if (frames_sent !== exp_frames || state !== 2'd0) begin
      errors++;
      $display("FAIL abort_count: got frames=%0d state=%0d required 0/0", frames_sent, state);
    end
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b required 1", tx_ready);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp, obs;
    @(negedge clk);
    force dut.frames_sent = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frames_sent;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    push_frame(8'h3C, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      exp = exp_q.pop_front();
      obs = {tx_ready, frame_active, stress_en, bit_strobe};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap_frame cyc %0d: got %b required %b", i, obs, exp);
      end
    end
    exp_frames = 32'd0;
    vectors++;
    if (frames_sent !== exp_frames) begin
      errors++;
      $display("FAIL wrap_count: got %h required %h", frames_sent, exp_frames);
    end
  endtask

  task automatic test_manchester();
    logic [3:0] exp, obs;
    tx_data_m  = 8'h80;
    tx_valid_m = 1'b1;
    push_frame(8'h80, 1'b1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid_m = 1'b0;
      exp = exp_q.pop_front();
      obs = {tx_ready_m, frame_active_m, stress_en_m, bit_strobe_m};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL manch_frame cyc %0d: got %b required %b", i, obs, exp);
      end
    end
    vectors++;
    if (frames_sent_m !== 32'd1) begin
      errors++;
      $display("FAIL manch_frames_sent: got %0d required 1", frames_sent_m);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors    = 0;
    errors     = 0;
    exp_frames = 32'd0;
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_data_m  = 8'h00;
    tx_valid_m = 1'b0;

    test_reset();
    test_idle_quiet();
    test_ook_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    test_manchester();

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
